// File: rtl/hist_window_bank.sv
// Per-channel hit histogrammer: counts buffer bits inside a start/stop or fixed-length
// window, snapshots the counts into shadow registers at window end, and reads them out by address.
module hist_window_bank #(
  parameter int NCH  = 10,
  parameter int CW   = 32,
  parameter int WINW = 32,
  parameter int AW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clkin,
  input  logic            reset,
  input  logic [NCH-1:0]  buffer,
  input  logic            resethist,
  input  logic            start,
  input  logic            stop,
  input  logic [WINW-1:0] window,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [CW-1:0]   rd_data,
  output logic            rd_ovf,
  output logic            rd_valid,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            resethist2;
  logic [WINW-1:0] wincnt;

  logic [CW-1:0]   cnt     [NCH];
  logic [CW-1:0]   cnt_inc [NCH];
  logic [NCH-1:0]  ovf;
  logic [NCH-1:0]  ovf_inc;
  logic [CW-1:0]   shadow  [NCH];
  logic [NCH-1:0]  shadow_ovf;

  logic            clear_live;
  logic            count_en;
  logic            snap;
  logic [CW-1:0]   rd_sel_data;
  logic            rd_sel_ovf;

  // Saturating increment: a hit on a full counter holds the count and raises ovf.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ovf_inc = ovf;
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i] = cnt[i];
      if (&cnt[i]) begin
        ovf_inc[i] = ovf[i] | buffer[i];
      end else begin
        cnt_inc[i] = cnt[i] + CW'(buffer[i]);
      end
    end
  end

  always_comb begin
    state_next = state;
    clear_live = 1'b0;
    count_en   = 1'b0;
    snap       = 1'b0;
    if (resethist2) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clear_live = 1'b1;
            state_next = COUNT;
          end
        end
        COUNT: begin
          count_en = 1'b1;
          // wincnt only reaches 1 when a nonzero window was latched
          if (stop || (wincnt == WINW'(1))) begin
            snap       = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          if (start) begin
            clear_live = 1'b1;
            state_next = COUNT;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resethist2 <= 1'b0;
      wincnt     <= '0;
    end else begin
      state      <= state_next;
      resethist2 <= resethist;
      if (clear_live) begin
        wincnt <= window;
      end else if (count_en && (wincnt != '0)) begin
        wincnt <= wincnt - WINW'(1);
      end
    end
  end

  // NOTE: the counter and shadow arrays are plain flops, not RAM, so they take the async reset.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      ovf        <= '0;
      shadow_ovf <= '0;
    end else if (resethist2) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      ovf        <= '0;
      shadow_ovf <= '0;
    end else begin
      if (clear_live) begin
        for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        ovf <= '0;
      end else if (count_en) begin
        for (int i = 0; i < NCH; i++) cnt[i] <= cnt_inc[i];
        ovf <= ovf_inc;
      end
      // The snapshot includes the hits of the end edge itself.
      if (snap) begin
        for (int i = 0; i < NCH; i++) shadow[i] <= cnt_inc[i];
        shadow_ovf <= ovf_inc;
      end
    end
  end

  // Out-of-range addresses match no channel and read as zero.
  always_comb begin
    rd_sel_data = '0;
    rd_sel_ovf  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_addr == AW'(i)) begin
        rd_sel_data = shadow[i];
        rd_sel_ovf  = shadow_ovf[i];
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_sel_data;
        rd_ovf  <= rd_sel_ovf;
      end
    end
  end

  assign busy = (state == COUNT);
  assign done = (state == DONE);

endmodule
